// File: rtl/my_irq_ctrl.sv
// -----------------------------------------------------------------------------
// my_irq_ctrl
// Machine-mode interrupt controller sitting in front of the privilege/CSR unit.
// Synchronises the external interrupt lines, forms per-source pending state,
// picks the lowest-index eligible source, handshakes with the pipeline for an
// instruction boundary and tracks the single in-service interrupt until mret.
//
// Optional feature macro: MY_IRQ_EDGE_EN
//   defined   -> edge-triggered pending bits (set on a rising edge of the
//                synchronised line, cleared when that source is taken)
//   undefined -> level-sensitive pending (pending mirrors the synchronised lines)
//
// Parameters:
//   NUM_IRQ      number of external sources (1..32), source k reports id k
//   SYNC_STAGES  synchroniser depth per line (2..4)
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   irq_lines_i    raw asynchronous interrupt lines
//   irq_enable_i   per-source enable mask
//   mstatus_mie_i  global machine interrupt enable
//   irq_req_o      request to the pipeline to redirect to the trap vector
//   irq_ack_i      pipeline accepts the request at an instruction boundary
//   irq_taken_o    one-cycle strobe to the privilege unit (ack cycle)
//   irq_o          interrupt flag for mcause, identical to irq_taken_o
//   irq_id_o       id of the requested / in-service source
//   mret_i         decoded mret retiring
//   irq_done_o     one-cycle strobe restoring mstatus (mret cycle in service)
//   irq_busy_o     an interrupt is in service
//   pending_o      current pending vector
// -----------------------------------------------------------------------------
module my_irq_ctrl #(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_lines_i,
    input  logic [NUM_IRQ-1:0] irq_enable_i,
    input  logic               mstatus_mie_i,
    output logic               irq_req_o,
    input  logic               irq_ack_i,
    output logic               irq_taken_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    input  logic               mret_i,
    output logic               irq_done_o,
    output logic               irq_busy_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] pending_s;

    // Next value of every synchroniser stage: shift the raw lines in.
    always_comb begin
        sync_d[0] = irq_lines_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Synchroniser flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {NUM_IRQ{1'b0}};
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM registers (declared early: the edge-mode clear uses irq_id_o)
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [4:0] id_q, id_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;

`ifdef MY_IRQ_EDGE_EN
    // ------------------------------------------------------------------
    // Edge-triggered pending state
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_prev_q, sync_prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] clr_s;

    // Clear the taken source in the ack cycle; a simultaneous new edge wins.
    always_comb begin
        clr_s = {NUM_IRQ{1'b0}};
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (irq_taken_o && (id_q == 5'(k))) begin
                clr_s[k] = 1'b1;
            end else begin
                clr_s[k] = 1'b0;
            end
        end
        sync_prev_d = sync_s;
        pend_d      = (pend_q & ~clr_s) | (sync_s & ~sync_prev_q);
    end

    // Pending and previous-sync flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_prev_q <= {NUM_IRQ{1'b0}};
            pend_q      <= {NUM_IRQ{1'b0}};
        end else begin
            sync_prev_q <= sync_prev_d;
            pend_q      <= pend_d;
        end
    end

    assign pending_s = pend_q;
`else
    // Level-sensitive: pending simply follows the synchronised lines.
    assign pending_s = sync_s;
`endif

    // ------------------------------------------------------------------
    // Eligibility and fixed-priority arbitration
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] elig_s;
    logic [4:0]         win_s;
    logic               any_s;
    logic [31:0]        pend_ext_s;
    logic [31:0]        en_ext_s;
    logic               cur_ok_s;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        if (mstatus_mie_i) begin
            elig_s = pending_s & irq_enable_i;
        end else begin
            elig_s = {NUM_IRQ{1'b0}};
        end
        win_s = 5'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (elig_s[k]) begin
                win_s = 5'(k);
            end else begin
                win_s = win_s;
            end
        end
        any_s = |elig_s;
    end

    // Zero-extend to 32 bits so the 5-bit latched id can index safely.
    always_comb begin
        pend_ext_s = 32'd0;
        en_ext_s   = 32'd0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            pend_ext_s[k] = pending_s[k];
            en_ext_s[k]   = irq_enable_i[k];
        end
        cur_ok_s = pend_ext_s[id_q] & en_ext_s[id_q];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // Next-state logic; the ack takes precedence over every withdraw reason.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (mstatus_mie_i && any_s) begin
                    state_d = ST_REQ;
                    id_d    = win_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d = ST_SERVICE;
                end else if (!mstatus_mie_i || !cur_ok_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (mret_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d == ST_SERVICE);
    end

    // State and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= 5'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    // Strobes are combinational so the privilege unit captures on the same edge.
    assign irq_taken_o = req_q & irq_ack_i;
    assign irq_o       = irq_taken_o;
    assign irq_done_o  = busy_q & mret_i;
    assign irq_req_o   = req_q;
    assign irq_busy_o  = busy_q;
    assign irq_id_o    = id_q;
    assign pending_o   = pending_s;

endmodule

// File: tb/tb_my_irq_ctrl.sv
module tb_my_irq_ctrl;

    localparam int N = 16;
    localparam int S = 2;
`ifdef MY_IRQ_EDGE_EN
    localparam int LAT = S + 2;
`else
    localparam int LAT = S + 1;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] irq_lines_i = '0;
    logic [N-1:0] irq_enable_i = '0;
    logic         mstatus_mie_i = 1'b0;
    logic         irq_ack_i = 1'b0;
    logic         mret_i = 1'b0;
    logic         irq_req_o, irq_taken_o, irq_o, irq_done_o, irq_busy_o;
    logic [4:0]   irq_id_o;
    logic [N-1:0] pending_o;

    int total = 0;
    int bad   = 0;

    my_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .irq_lines_i(irq_lines_i),
        .irq_enable_i(irq_enable_i), .mstatus_mie_i(mstatus_mie_i),
        .irq_req_o(irq_req_o), .irq_ack_i(irq_ack_i), .irq_taken_o(irq_taken_o),
        .irq_o(irq_o), .irq_id_o(irq_id_o), .mret_i(mret_i),
        .irq_done_o(irq_done_o), .irq_busy_o(irq_busy_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    logic [N-1:0] hist[$];   // raw line values sampled at past edges
    logic [N-1:0] m_pend;
    logic [N-1:0] m_prev;
    int           m_state;   // 0 idle, 1 requesting, 2 in service
    logic [4:0]   m_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_sync();
        if (hist.size() >= S) return hist[hist.size() - S];
        return '0;
    endfunction

    function automatic logic [N-1:0] m_pending();
`ifdef MY_IRQ_EDGE_EN
        return m_pend;
`else
        return m_sync();
`endif
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_pend  = '0;
        m_prev  = '0;
        m_state = 0;
        m_id    = 5'd0;
    endtask

    task automatic model_edge();
        logic [N-1:0] p, s, e, clr;
        int w;
        if (rst_i) begin
            model_reset();
            return;
        end
        p = m_pending();
        s = m_sync();
        clr = '0;
        if (m_state == 1 && irq_ack_i) clr[m_id] = 1'b1;
        m_pend = (m_pend & ~clr) | (s & ~m_prev);
        m_prev = s;
        case (m_state)
            0: begin
                e = mstatus_mie_i ? (p & irq_enable_i) : '0;
                w = lowest(e);
                if (w >= 0) begin
                    m_state = 1;
                    m_id    = 5'(w);
                end
            end
            1: begin
                if (irq_ack_i) m_state = 2;
                else if (!mstatus_mie_i || !p[m_id] || !irq_enable_i[m_id]) m_state = 0;
            end
            default: if (mret_i) m_state = 0;
        endcase
        hist.push_back(irq_lines_i);
        if (hist.size() > S) void'(hist.pop_front());
    endtask

    // One clock cycle: compare every output mid-cycle, then advance the model.
    task automatic step();
        logic r;
        #3;
        r = rst_i;
        chk("req",     {31'd0, irq_req_o},   r ? 32'd0 : 32'(m_state == 1));
        chk("busy",    {31'd0, irq_busy_o},  r ? 32'd0 : 32'(m_state == 2));
        chk("taken",   {31'd0, irq_taken_o}, r ? 32'd0 : 32'(m_state == 1 && irq_ack_i));
        chk("irq",     {31'd0, irq_o},       r ? 32'd0 : 32'(m_state == 1 && irq_ack_i));
        chk("done",    {31'd0, irq_done_o},  r ? 32'd0 : 32'(m_state == 2 && mret_i));
        chk("id",      {27'd0, irq_id_o},    r ? 32'd0 : {27'd0, m_id});
        chk("pending", 32'(pending_o),       r ? 32'd0 : 32'(m_pending()));
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget && !irq_req_o; i++) step();
        chk("wait_req", {31'd0, irq_req_o}, 32'd1);
    endtask

    task automatic finish_service();
        irq_lines_i = '0;
        steps(S + 1);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        steps(2);
    endtask

    initial begin
        model_reset();
        @(posedge clk_i);
        #1;
        steps(2);
        rst_i = 1'b0;
        steps(2);

        // Basic take and latency
        irq_enable_i  = 16'h0001;
        mstatus_mie_i = 1'b1;
        irq_lines_i   = 16'h0001;
        steps(LAT - 1);
        chk("lat_early", {31'd0, irq_req_o}, 32'd0);
        step();
        chk("lat_exact", {31'd0, irq_req_o}, 32'd1);
        irq_ack_i = 1'b1;
        #1;
        chk("t1_taken", {31'd0, irq_taken_o}, 32'd1);
        chk("t1_id", {27'd0, irq_id_o}, 32'd0);
        step();
        irq_ack_i = 1'b0;
        chk("t1_busy", {31'd0, irq_busy_o}, 32'd1);
        irq_lines_i = '0;
        steps(S + 1);
        mret_i = 1'b1;
        #1;
        chk("t1_done", {31'd0, irq_done_o}, 32'd1);
        step();
        mret_i = 1'b0;
        chk("t1_idle", {31'd0, irq_busy_o}, 32'd0);
        steps(2);

        // Priority
        irq_enable_i = 16'hffff;
        irq_lines_i  = 16'h0088;
        wait_req(10);
        chk("prio_3", {27'd0, irq_id_o}, 32'd3);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        irq_lines_i = 16'h0080;
        steps(S + 1);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        wait_req(10);
        chk("prio_7", {27'd0, irq_id_o}, 32'd7);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        finish_service();

        // Withdraw, then ack beating a withdraw
        irq_lines_i = 16'h0002;
        wait_req(10);
        mstatus_mie_i = 1'b0;
        step();
        chk("wd_req", {31'd0, irq_req_o}, 32'd0);
        mstatus_mie_i = 1'b1;
        wait_req(10);
        mstatus_mie_i = 1'b0;
        irq_ack_i = 1'b1;
        #1;
        chk("wd_ack_taken", {31'd0, irq_taken_o}, 32'd1);
        step();
        irq_ack_i = 1'b0;
        mstatus_mie_i = 1'b1;
        chk("wd_ack_busy", {31'd0, irq_busy_o}, 32'd1);
        finish_service();

        // Nesting blocked, back-to-back timing
        irq_lines_i = 16'h0010;
        wait_req(10);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        irq_lines_i = 16'h0004;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("nest_noreq", {31'd0, irq_req_o}, 32'd0);
        end
        mret_i = 1'b1;
        #1;
        chk("nest_done", {31'd0, irq_done_o}, 32'd1);
        step();
        mret_i = 1'b0;
        chk("b2b_gap", {31'd0, irq_req_o}, 32'd0);
        step();
        chk("b2b_req", {31'd0, irq_req_o}, 32'd1);
        chk("b2b_id", {27'd0, irq_id_o}, 32'd2);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        finish_service();

`ifdef MY_IRQ_EDGE_EN
        // Edge mode: short pulse latches, ack clears, coincident edge keeps it
        irq_lines_i = 16'h0020;
        step();
        irq_lines_i = '0;
        steps(2);
        chk("edge_set", 32'(pending_o[5]), 32'd1);
        steps(3);
        chk("edge_hold", 32'(pending_o[5]), 32'd1);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        chk("edge_clr", 32'(pending_o[5]), 32'd0);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        irq_lines_i = 16'h0020;
        step();
        irq_lines_i = '0;
        steps(3);
        irq_lines_i = 16'h0020;
        step();
        irq_lines_i = '0;
        step();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        chk("edge_keep", 32'(pending_o[5]), 32'd1);
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        wait_req(10);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        finish_service();
`endif

        // Asynchronous reset in service
        irq_lines_i = 16'h0040;
        wait_req(10);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        chk("rst_pre_id", {27'd0, irq_id_o}, 32'd6);
        #1;
        rst_i = 1'b1;
        irq_lines_i = '0;
        #1;
        chk("rst_busy", {31'd0, irq_busy_o}, 32'd0);
        chk("rst_req", {31'd0, irq_req_o}, 32'd0);
        chk("rst_pend", 32'(pending_o), 32'd0);
        chk("rst_id", {27'd0, irq_id_o}, 32'd0);
        step();
        rst_i = 1'b0;
        steps(2);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) irq_enable_i = N'($urandom);
            if ($urandom_range(99) < 20) irq_lines_i[$urandom_range(N - 1)] ^= 1'b1;
            mstatus_mie_i = ($urandom_range(99) < 90);
            irq_ack_i     = ($urandom_range(99) < 30);
            mret_i        = ($urandom_range(99) < 20);
            rst_i         = ($urandom_range(999) < 5);
            step();
        end
        rst_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
